// File: rtl/load_hazard_scoreboard.sv
// Load-use hazard scoreboard for VLIW decode/issue: stalls bundles touching registers whose load data is not yet in the RF.
// Optional stall-cycle performance counter built only when HAZARD_PERF_EN is defined.
module load_hazard_scoreboard #(
  parameter int LOAD_LAT = 2,
  parameter int NUM_REGS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bundle_valid,
  input  logic [4:0]          ixu1_rs1,
  input  logic [4:0]          ixu1_rs2,
  input  logic [4:0]          ixu2_rs1,
  input  logic [4:0]          ixu2_rs2,
  input  logic [4:0]          lsu_rs1,
  input  logic [4:0]          lsu_rs2,
  input  logic [4:0]          branch_rs1,
  input  logic [4:0]          branch_rs2,
  input  logic [4:0]          ixu1_rd,
  input  logic [4:0]          ixu2_rd,
  input  logic [4:0]          lsu_rd,
  input  logic                lsu_is_load,
  input  logic                pipe_hold,
  input  logic                flush,
  output logic                issue_stall,
  output logic                bundle_issue,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic                waw_err,
  output logic [31:0]         stall_cycles
);

  localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
  // The issuing edge is itself the first advancing cycle, so the counter
  // starts one short: LOAD_LAT=2 gives exactly one bubble, LOAD_LAT=1 none.
  localparam logic [CW-1:0] LOAD_INIT = CW'(LOAD_LAT - 1);

  logic [CW-1:0] cnt_q [NUM_REGS];
  logic [CW-1:0] cnt_d [NUM_REGS];
  logic [31:0]   pend_ext;
  logic          load_set;
  logic          waw_hit;
  logic          waw_err_q;

  function automatic logic hit(input logic [31:0] pend, input logic [4:0] a);
    return (a != 5'd0) && pend[a];
  endfunction

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) pending_mask[r] = (cnt_q[r] != '0);
  end

  assign pend_ext = 32'(pending_mask);

  // Reads see pre-bundle state, so a same-bundle load never stalls its own readers.
  assign issue_stall = bundle_valid & (
      hit(pend_ext, ixu1_rs1)   | hit(pend_ext, ixu1_rs2)   |
      hit(pend_ext, ixu2_rs1)   | hit(pend_ext, ixu2_rs2)   |
      hit(pend_ext, lsu_rs1)    | hit(pend_ext, lsu_rs2)    |
      hit(pend_ext, branch_rs1) | hit(pend_ext, branch_rs2) |
      hit(pend_ext, ixu1_rd)    | hit(pend_ext, ixu2_rd)    | hit(pend_ext, lsu_rd));

  assign bundle_issue = bundle_valid & ~issue_stall & ~pipe_hold & ~flush;
  assign load_set     = bundle_issue & lsu_is_load & (lsu_rd != 5'd0);

  assign waw_hit = ((ixu1_rd != 5'd0) && (ixu1_rd == ixu2_rd)) ||
                   ((ixu1_rd != 5'd0) && (ixu1_rd == lsu_rd))  ||
                   ((ixu2_rd != 5'd0) && (ixu2_rd == lsu_rd));

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!pipe_hold && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      if (load_set && lsu_rd == 5'(r)) cnt_d[r] = LOAD_INIT;
    end
    cnt_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      waw_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      if (bundle_issue && waw_hit) waw_err_q <= 1'b1;
    end
  end

  assign waw_err = waw_err_q;

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (issue_stall && !pipe_hold && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
